sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYC, default 2: SRAM access-phase length in clocks; legal range 2..15.
REQ-002 Parameter DL_INDEX, default 8'h00: the ioctl_index value accepted as an SRAM image download.
REQ-003 Parameter DL_BASE, default 21'h000000: SRAM byte address of download offset 0.
REQ-004 clk_25  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU access request; level, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
REQ-008 cpu_addr  in  21  CPU byte address.
REQ-009 cpu_din  in  8  CPU write data.
REQ-010 cpu_dout  out  8  CPU read data; valid in the cpu_ack cycle and held until the next read completes.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 ioctl_download, ioctl_wr, ioctl_addr[24:0], ioctl_dout[7:0], ioctl_index[7:0]  in  loader download bus; ioctl_wr is a one-cycle pulse.
REQ-013 ioctl_wait  out  1  loader stall; high while a captured download byte is not yet written.
REQ-014 SRAM_A  out  21, SRAM_D_out  out  8, SRAM_D_in  in  8, SRAM_D_oe  out  1, SRAM_WE_n  out  1: external SRAM; the tristate buffer lives at top level.

Function
REQ-015 The FSM SHALL have states IDLE, ACC and DONE.
- IDLE -> ACC on grant.
- ACC lasts exactly ACCESS_CYC cycles.
- DONE lasts 1 cycle, then returns to IDLE.
REQ-016 Grant priority SHALL be: pending download byte, then cpu_req. cpu_req SHALL NOT be granted while ioctl_download=1.
REQ-017 An ioctl_wr pulse with ioctl_download=1, ioctl_index==DL_INDEX and ioctl_addr[24:21]==0 SHALL be captured into a one-entry hold register in that cycle, in any FSM state.
REQ-018 An ioctl_wr pulse failing any REQ-017 condition SHALL be dropped: no SRAM cycle and no ioctl_wait.
REQ-019 ioctl_wait SHALL rise the cycle after capture and fall the cycle after the download write's DONE cycle.
REQ-020 The download address SHALL be (DL_BASE + ioctl_addr[20:0]) mod 2^21, wrapping silently.
REQ-021 Write cycles (CPU or download):
- SRAM_A, SRAM_D_out and SRAM_D_oe=1 driven for all ACC cycles and the DONE cycle.
- SRAM_WE_n=1 in the first ACC cycle, 0 in the remaining ACC cycles, 1 in DONE.
REQ-022 CPU read cycle:
- SRAM_D_oe=0 and SRAM_WE_n=1 throughout.
- SRAM_D_in is latched into cpu_dout on the last ACC cycle.
REQ-023 CPU latency: cpu_ack SHALL pulse in the DONE cycle, i.e. ACCESS_CYC+1 cycles after the grant edge.
REQ-024 If cpu_req is still high in the IDLE cycle after DONE, it SHALL be treated as a new request; the requester must drop cpu_req on cpu_ack.
REQ-025 A CPU access already in ACC when ioctl_download rises SHALL complete normally, including cpu_ack.
REQ-026 Outside active cycles (IDLE):
- SRAM_WE_n=1, SRAM_D_oe=0.
- SRAM_A holds its last value.

Reset
REQ-027 On reset_n=0, asynchronously:
- FSM to IDLE.
- Hold register empty.
- cpu_ack=0, ioctl_wait=0, SRAM_WE_n=1, SRAM_D_oe=0.
- SRAM_A=0, SRAM_D_out=0, cpu_dout=0.
REQ-028 Reset asserted mid-access SHALL abort the access and discard any pending download byte; SRAM_WE_n SHALL go high immediately.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the SRAM address width (21) and the data width (8).
REQ-030 The design SHALL be a single module with no sub-modules; the ACC-phase down-counter is 4 bits.

Verification
REQ-031 Reset, then CPU read at 21'h00100 with the SRAM model returning 8'hA5 -> SRAM_WE_n stays 1; cpu_ack 3 cycles after grant; cpu_dout=8'hA5.
REQ-032 CPU write of 8'h3C to 21'h1FFFF -> exactly one SRAM_WE_n low cycle; model holds 8'h3C; cpu_ack once.
REQ-033 Download of 4 bytes (index 0, addr 0..3, ioctl_wr every 2 cycles) -> ioctl_wait stalls the loader; SRAM holds the 4 bytes at DL_BASE..DL_BASE+3; cpu_req held high gets no ack.
REQ-034 ioctl_wr captured during a CPU ACC phase -> CPU completes first, then the download write; ioctl_wait high for the whole interval.
REQ-035 Dropped writes: ioctl_addr=25'h200000 -> no SRAM write, ioctl_wait=0; ioctl_index=1 -> no SRAM write, ioctl_wait=0.
REQ-036 reset_n pulsed low in the second ACC cycle of a download write -> SRAM_WE_n=1 immediately; after release the FSM is in IDLE, ioctl_wait=0 and no write occurs.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arbiter_pkg;

    localparam int SRAM_AW = 21;
    localparam int SRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one async SRAM between a CPU port and a loader download stream.
// Latency: cpu_ack in the DONE cycle, ACCESS_CYC+1 clocks after the grant cycle.
// Backpressure: loader held by ioctl_wait while a captured byte is unwritten; CPU waits for cpu_ack.
//
// Ports: clk_25/reset_n; cpu_* request/ack port; ioctl_* loader bus with ioctl_wait stall;
// SRAM_* external SRAM pins (tristate resolved by the parent).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned        ACCESS_CYC = 2,
    parameter logic [7:0]         DL_INDEX   = 8'h00,
    parameter logic [SRAM_AW-1:0] DL_BASE    = 21'h000000
) (
    input  logic               clk_25,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [SRAM_DW-1:0] cpu_din,
    output logic [SRAM_DW-1:0] cpu_dout,
    output logic               cpu_ack,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic [7:0]         ioctl_index,
    output logic               ioctl_wait,
    output logic [SRAM_AW-1:0] SRAM_A,
    output logic [SRAM_DW-1:0] SRAM_D_out,
    input  logic [SRAM_DW-1:0] SRAM_D_in,
    output logic               SRAM_D_oe,
    output logic               SRAM_WE_n
);

    // Counter is loaded on grant and reaches zero in the last ACC cycle.
    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYC - 1);

    state_t             state, state_nxt;
    logic [3:0]         acc_cnt;

    logic               hold_vld;
    logic [SRAM_AW-1:0] hold_addr;
    logic [SRAM_DW-1:0] hold_dat;

    // Attributes of the cycle currently on the SRAM bus.
    logic               cyc_we;
    logic               cyc_dl;

    logic               dl_capture;
    logic               grant_dl;
    logic               grant_cpu;
    logic               acc_last;

    assign dl_capture = ioctl_wr && ioctl_download && (ioctl_index == DL_INDEX)
                        && (ioctl_addr[24:21] == 4'd0);
    assign grant_dl   = (state == IDLE) && hold_vld;
    // A CPU request is only considered when no download byte is pending.
    assign grant_cpu  = (state == IDLE) && !hold_vld && cpu_req && !ioctl_download;
    assign acc_last   = (state == ACC) && (acc_cnt == 4'd0);

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        SRAM_WE_n = 1'b1;
        SRAM_D_oe = 1'b0;
        cpu_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_dl || grant_cpu) state_nxt = ACC;
            end
            ACC: begin
                SRAM_D_oe = cyc_we;
                // First ACC cycle sets up address/data before the strobe falls.
                SRAM_WE_n = !(cyc_we && (acc_cnt != ACC_LOAD));
                if (acc_cnt == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                SRAM_D_oe = cyc_we;
                cpu_ack   = !cyc_dl;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt    <= 4'd0;
            hold_vld   <= 1'b0;
            hold_addr  <= '0;
            hold_dat   <= '0;
            cyc_we     <= 1'b0;
            cyc_dl     <= 1'b0;
            SRAM_A     <= '0;
            SRAM_D_out <= '0;
            cpu_dout   <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (grant_dl || grant_cpu) begin
                acc_cnt    <= ACC_LOAD;
                cyc_dl     <= grant_dl;
                cyc_we     <= grant_dl || cpu_we;
                SRAM_A     <= grant_dl ? hold_addr : cpu_addr;
                SRAM_D_out <= grant_dl ? hold_dat  : cpu_din;
            end else if (state == ACC && acc_cnt != 4'd0) begin
                acc_cnt <= acc_cnt - 4'd1;
            end

            // Grant empties the hold; a same-cycle capture refills it.
            if (grant_dl) hold_vld <= 1'b0;
            if (dl_capture) begin
                hold_vld  <= 1'b1;
                hold_addr <= DL_BASE + ioctl_addr[SRAM_AW-1:0];
                hold_dat  <= ioctl_dout;
            end

            if (acc_last && !cyc_we) cpu_dout <= SRAM_D_in;

            // Stall stays up while any captured byte is still unwritten.
            if (dl_capture) begin
                ioctl_wait <= 1'b1;
            end else if (state == DONE && cyc_dl && !hold_vld) begin
                ioctl_wait <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences, random ops vs byte-map model.
// Latency: n/a.
// Backpressure: loader model honours ioctl_wait; CPU model holds cpu_req until cpu_ack.
module tb_sram_arbiter;

    localparam int unsigned AC  = 2;
    localparam logic [7:0]  DLI = 8'h00;
    localparam logic [20:0] DLB = 21'h1FFFFE;   // near the top so downloads wrap

    logic        clk_25 = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_ack;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        ioctl_wait;
    logic [20:0] SRAM_A;
    logic [7:0]  SRAM_D_out, SRAM_D_in;
    logic        SRAM_D_oe, SRAM_WE_n;

    sram_arbiter #(.ACCESS_CYC(AC), .DL_INDEX(DLI), .DL_BASE(DLB)) dut (
        .clk_25(clk_25), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .SRAM_A(SRAM_A), .SRAM_D_out(SRAM_D_out), .SRAM_D_in(SRAM_D_in),
        .SRAM_D_oe(SRAM_D_oe), .SRAM_WE_n(SRAM_WE_n)
    );

    always #20 clk_25 = ~clk_25;

    // SRAM model: every cycle with WE_n low stores one byte and logs the address.
    bit [7:0]    mem [bit [20:0]];
    logic [20:0] wr_log [$];
    int          ack_cnt = 0;

    always @(negedge clk_25) begin
        if (SRAM_WE_n === 1'b0) begin
            mem[SRAM_A] = SRAM_D_out;
            wr_log.push_back(SRAM_A);
        end
        if (cpu_ack === 1'b1) ack_cnt++;
        SRAM_D_in = mem.exists(SRAM_A) ? mem[SRAM_A] : 8'h00;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk_25);
        #1;
    endtask

    function automatic logic [20:0] dl_target(input int off);
        return 21'((int'(DLB) + off) % 2097152);
    endfunction

    // One CPU access started from IDLE; returns cycles to ack, WE_n-low cycles, bus errors.
    task automatic cpu_op(input logic we, input logic [20:0] addr, input logic [7:0] din,
                          output int lat, output int lows, output int berr);
        int n0;
        n0 = wr_log.size();
        berr = 0;
        lat  = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        do begin
            tick();
            lat++;
            if (SRAM_D_oe !== we || SRAM_A !== addr || (we && SRAM_D_out !== din)) berr++;
        end while (cpu_ack !== 1'b1 && lat < 40);
        cpu_req = 1'b0;
        lows = wr_log.size() - n0;
    endtask

    // One loader byte; returns number of cycles ioctl_wait stayed high afterwards.
    task automatic dl_op(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx,
                         output int whigh);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; ioctl_index = idx;
        tick();
        ioctl_wr = 1'b0;
        whigh = 0;
        while (ioctl_wait === 1'b1 && whigh < 40) begin
            whigh++;
            tick();
        end
    endtask

    typedef struct {
        logic        we;
        logic [20:0] addr;
        logic [7:0]  din;
        logic        pre;
        logic [7:0]  pre_dat;
        logic [7:0]  exp_dout;
        int          exp_lows;
    } vec_t;

    vec_t        vecs [6];
    logic [20:0] cpu_pool [7];
    bit [7:0]    ref_mem [bit [20:0]];

    initial begin
        int lat, lows, berr, wh, n0, a0, gap;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lows, berr, wh, n0, a0, gap;

        vecs[0] = '{1'b0, 21'h00100, 8'h00, 1'b1, 8'hA5, 8'hA5, 0};
        vecs[1] = '{1'b1, 21'h1FFFF,  8'h3C, 1'b0, 8'h00, 8'hA5, int'(AC) - 1};
        vecs[2] = '{1'b0, 21'h1FFFF,  8'h00, 1'b0, 8'h00, 8'h3C, 0};
        vecs[3] = '{1'b0, 21'h1FFFFF, 8'h00, 1'b1, 8'h5A, 8'h5A, 0};
        vecs[4] = '{1'b1, 21'h000000, 8'hFF, 1'b0, 8'h00, 8'h5A, int'(AC) - 1};
        vecs[5] = '{1'b0, 21'h000000, 8'h00, 1'b0, 8'h00, 8'hFF, 0};
        cpu_pool = '{21'h0, 21'h1, 21'h2, 21'h3, 21'h1FFFFE, 21'h1FFFFF, 21'h00100};

        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        #30;
        chk("reset ack_wait_wen_oe", 32'({cpu_ack, ioctl_wait, SRAM_WE_n, SRAM_D_oe}), 32'b0010);
        chk("reset sram_a", 32'(SRAM_A), 0);
        chk("reset sram_d_out", 32'(SRAM_D_out), 0);
        chk("reset cpu_dout", 32'(cpu_dout), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // CPU vector table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre) mem[vecs[i].addr] = vecs[i].pre_dat;
            cpu_op(vecs[i].we, vecs[i].addr, vecs[i].din, lat, lows, berr);
            chk($sformatf("vec%0d latency", i), lat, AC + 1);
            chk($sformatf("vec%0d cpu_dout", i), 32'(cpu_dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d we_low_cycles", i), lows, vecs[i].exp_lows);
            chk($sformatf("vec%0d bus_errors", i), berr, 0);
            if (vecs[i].we) chk($sformatf("vec%0d sram_byte", i), 32'(mem[vecs[i].addr]), 32'(vecs[i].din));
            tick();
            chk($sformatf("vec%0d ack_one_cycle", i), 32'(cpu_ack), 0);
        end

        // Four-byte download with a CPU request held high throughout
        ioctl_download = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00100;
        a0 = ack_cnt; n0 = wr_log.size();
        for (int i = 0; i < 4; i++) begin
            dl_op(25'(i), 8'hD0 + 8'(i), DLI, wh);
            chk($sformatf("dl%0d wait_cycles", i), wh, AC + 2);
            tick();
        end
        chk("dl cpu_no_ack", ack_cnt - a0, 0);
        chk("dl write_cycles", wr_log.size() - n0, 4 * (AC - 1));
        cpu_req = 1'b0;
        tick();
        ioctl_download = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("dl%0d sram_byte", i), 32'(mem[dl_target(i)]), 32'(8'hD0 + 8'(i)));

        // Download byte captured during a CPU ACC phase
        n0 = wr_log.size(); gap = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00042; cpu_din = 8'h77;
        tick();
        ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hE1; ioctl_index = DLI;
        tick();
        ioctl_wr = 1'b0; lat = 2;
        while (cpu_ack !== 1'b1 && lat < 40) begin
            if (ioctl_wait !== 1'b1) gap++;
            tick();
            lat++;
        end
        cpu_req = 1'b0;
        chk("ovl cpu_latency", lat, AC + 1);
        chk("ovl cpu_written_first", wr_log.size() - n0, AC - 1);
        wh = 0;
        while (ioctl_wait === 1'b1 && wh < 40) begin
            tick();
            wh++;
        end
        chk("ovl wait_gap", gap, 0);
        chk("ovl writes_when_wait_fell", wr_log.size() - n0, 2 * (AC - 1));
        chk("ovl dl_addr", 32'((wr_log.size() > n0 + int'(AC) - 1) ? wr_log[n0 + AC - 1] : 21'h0AAAAA),
            32'(dl_target(16)));
        chk("ovl dl_byte", 32'(mem[dl_target(16)]), 32'h0E1);
        chk("ovl cpu_byte", 32'(mem[21'h00042]), 32'h077);
        ioctl_download = 1'b0;
        tick();

        // Dropped loader writes
        n0 = wr_log.size();
        ioctl_download = 1'b1;
        dl_op(25'h200000, 8'h11, DLI, wh);
        chk("drop_addr wait", wh, 0);
        dl_op(25'h000005, 8'h22, 8'h01, wh);
        chk("drop_index wait", wh, 0);
        ioctl_download = 1'b0;
        dl_op(25'h000005, 8'h33, DLI, wh);
        chk("drop_nodl wait", wh, 0);
        repeat (4) tick();
        chk("drop no_write", wr_log.size() - n0, 0);

        // Reset in the second ACC cycle of a download write
        n0 = wr_log.size();
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = 25'h3; ioctl_dout = 8'h99; ioctl_index = DLI;
        tick();
        ioctl_wr = 1'b0;
        tick();
        @(posedge clk_25);
        #5;
        chk("rst_mid we_n_low_before", 32'(SRAM_WE_n), 0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid we_n_high", 32'(SRAM_WE_n), 1);
        chk("rst_mid oe_low", 32'(SRAM_D_oe), 0);
        chk("rst_mid wait_low", 32'(ioctl_wait), 0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("rst_mid wait_after", 32'(ioctl_wait), 0);
        chk("rst_mid no_write", wr_log.size() - n0, 0);
        ioctl_download = 1'b0;
        tick();
        cpu_op(1'b0, 21'h00100, 8'h00, lat, lows, berr);
        chk("rst_mid idle_latency", lat, AC + 1);
        chk("rst_mid read", 32'(cpu_dout), 32'h0A5);
        tick();

        // Random ops against a byte-map reference
        mem.delete();
        for (int k = 0; k < 60; k++) begin
            int          op;
            logic [20:0] a;
            logic [7:0]  d;
            logic [3:0]  hi;
            logic [7:0]  idx;
            int          off;
            bit          acc;
            op = int'($urandom_range(0, 2));
            a  = cpu_pool[$urandom_range(0, 6)];
            d  = 8'($urandom);
            if (op < 2) begin
                cpu_op(op == 1, a, d, lat, lows, berr);
                chk($sformatf("rnd%0d latency", k), lat, AC + 1);
                if (op == 0) chk($sformatf("rnd%0d read", k), 32'(cpu_dout),
                                 32'(ref_mem.exists(a) ? ref_mem[a] : 8'h00));
                else ref_mem[a] = d;
                tick();
            end else begin
                hi  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                idx = ($urandom_range(0, 3) == 0) ? 8'h01 : DLI;
                off = int'($urandom_range(0, 3));
                acc = (hi == 4'd0) && (idx == DLI);
                ioctl_download = 1'b1;
                dl_op({hi, 21'(off)}, d, idx, wh);
                chk($sformatf("rnd%0d wait_cycles", k), wh, acc ? AC + 2 : 0);
                if (acc) ref_mem[dl_target(off)] = d;
                ioctl_download = 1'b0;
                tick();
            end
        end
        foreach (ref_mem[key])
            chk($sformatf("final byte %0h", key), mem.exists(key) ? 32'(mem[key]) : 32'h100,
                32'(ref_mem[key]));
        chk("final byte_count", mem.num(), ref_mem.num());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
